cr_osf_dbg_step_sched: RTL and testbench

//  Command-driven single-step scheduler for one OSF debug FIFO (data or PDT).

---
 rtl/cr_osf_dbg_step_sched_if.sv | 28 ++
 rtl/cr_osf_dbg_step_sched.sv | 134 +++++++++++++
 tb/tb_cr_osf_dbg_step_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_osf_dbg_step_sched_if.sv
// Handshake bundle between the OSF register block / debug-FIFO control and the step scheduler.
// master = command and FIFO-status side, slave = the scheduler.
interface cr_osf_dbg_step_sched_if #(
    parameter int CNT_W = 16
) ();
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             fifo_empty;
    logic             fifo_head_eob;
    logic             ob_afull;
    logic             single_step_rd;
    logic             busy;
    logic [CNT_W-1:0] issued_cnt;
    logic             done;
    logic [1:0]       done_status;
    logic             cmd_rejected;

    modport master (
        output cmd_valid, cmd_op, cmd_count, fifo_empty, fifo_head_eob, ob_afull,
        input  single_step_rd, busy, issued_cnt, done, done_status, cmd_rejected
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, fifo_empty, fifo_head_eob, ob_afull,
        output single_step_rd, busy, issued_cnt, done, done_status, cmd_rejected
    );
endinterface

// File: rtl/cr_osf_dbg_step_sched.sv
// Command-driven single-step scheduler for one OSF debug FIFO: turns STEP_N / STEP_EOB
// commands into paced single_step_rd pulses, throttled by downstream almost-full.
module cr_osf_dbg_step_sched #(
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = 2,
    parameter int TMO_W   = 12,
    parameter int TMO_CYC = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cr_osf_dbg_step_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    localparam logic [1:0] OP_STEP_N   = 2'd0;
    localparam logic [1:0] OP_STEP_EOB = 2'd1;
    localparam logic [1:0] OP_ABORT    = 2'd2;
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ABORTED  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYC);
    localparam bit               TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_EN ? TMO_W'(TMO_CYC - 1) : '0;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic             mode_eob;
    logic             eob_seen;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] issued_cnt;
    logic [3:0]       gap;
    logic [TMO_W-1:0] timer;
    logic [1:0]       done_status;
    logic             cmd_rejected;

    logic step_cmd;
    logic abort_cmd;
    logic can_issue;
    logic issue;
    logic finished;

    assign step_cmd  = bus.cmd_valid && (bus.cmd_op == OP_STEP_N || bus.cmd_op == OP_STEP_EOB);
    assign abort_cmd = bus.cmd_valid && (bus.cmd_op == OP_ABORT) && (state == RUN || state == GAP);
    assign can_issue = !bus.fifo_empty && !bus.ob_afull;
    // An abort in the same cycle suppresses the pulse the RUN state would otherwise emit.
    assign issue     = (state == RUN) && can_issue && !abort_cmd;
    assign finished  = mode_eob ? eob_seen : (rem == '0);

    assign bus.single_step_rd = issue;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.issued_cnt     = issued_cnt;
    assign bus.done_status    = done_status;
    assign bus.cmd_rejected   = cmd_rejected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode_eob     <= 1'b0;
            eob_seen     <= 1'b0;
            rem          <= '0;
            issued_cnt   <= '0;
            gap          <= '0;
            timer        <= '0;
            done_status  <= ST_OK;
            cmd_rejected <= 1'b0;
        end else begin
            cmd_rejected <= step_cmd && (state != IDLE);
            case (state)
                IDLE: begin
                    if (step_cmd) begin
                        mode_eob    <= (bus.cmd_op == OP_STEP_EOB);
                        eob_seen    <= 1'b0;
                        rem         <= bus.cmd_count;
                        issued_cnt  <= '0;
                        timer       <= '0;
                        done_status <= ST_OK;
                        if (bus.cmd_op == OP_STEP_N && bus.cmd_count == '0) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort_cmd) begin
                        done_status <= ST_ABORTED;
                        state       <= DONE;
                    end else if (can_issue) begin
                        issued_cnt <= sat_inc_cnt(issued_cnt);
                        if (mode_eob) begin
                            eob_seen <= bus.fifo_head_eob;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                        timer <= '0;
                        gap   <= GAP_LOAD;
                        state <= GAP;
                    end else if (TMO_EN && timer >= TMO_LIM) begin
                        done_status <= ST_TIMEOUT;
                        state       <= DONE;
                    end else begin
                        timer <= sat_inc_tmo(timer);
                    end
                end
                GAP: begin
                    if (abort_cmd) begin
                        done_status <= ST_ABORTED;
                        state       <= DONE;
                    end else begin
                        gap <= gap - 1'b1;
                        if (gap == 4'd1) begin
                            state <= finished ? DONE : RUN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cr_osf_dbg_step_sched.sv
// Bench for cr_osf_dbg_step_sched: directed scenarios plus randomized segments scored
// against a timeline model that predicts pulse/done cycles from the pacing rules.
module tb_cr_osf_dbg_step_sched;
    localparam int CNT_W   = 4;
    localparam int GAP_CYC = 2;
    localparam int TMO_W   = 12;
    localparam int TMO_CYC = 16;
    localparam int MAXL    = 700;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       ST_OK    = 2'd0;
    localparam logic [1:0]       ST_ABORT = 2'd1;
    localparam logic [1:0]       ST_TMO   = 2'd2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cr_osf_dbg_step_sched_if #(.CNT_W(CNT_W)) bus ();

    cr_osf_dbg_step_sched #(
        .CNT_W(CNT_W), .GAP_CYC(GAP_CYC), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus of one segment
    bit               s_cv    [MAXL];
    logic [1:0]       s_op    [MAXL];
    logic [CNT_W-1:0] s_cnt   [MAXL];
    bit               s_empty [MAXL];
    bit               s_afull [MAXL];
    bit               s_eob   [MAXL];

    // Predicted outputs
    bit               e_rd   [MAXL+1];
    bit               e_busy [MAXL+1];
    bit               e_done [MAXL+1];
    bit               e_rej  [MAXL+1];
    logic [1:0]       e_st   [MAXL+1];
    logic [CNT_W-1:0] e_iss  [MAXL+1];

    logic [1:0]       m_status = ST_OK;
    logic [CNT_W-1:0] m_issued = '0;

    // Observations of the last segment
    int               q_rd[$];
    int               done_c;
    int               n_done;
    int               n_rej;
    logic [1:0]       done_st;
    logic [CNT_W-1:0] last_iss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic rd, input logic bsy, input logic dn,
                                         input logic rej, input logic [1:0] st,
                                         input logic [CNT_W-1:0] iss);
        return 32'({rd, bsy, dn, rej, st, iss});
    endfunction

    function automatic int qget(input int i);
        return (i < q_rd.size()) ? q_rd[i] : -1;
    endfunction

    task automatic seg_clear(input int len, input bit empty, input bit afull);
        for (int i = 0; i < len; i++) begin
            s_cv[i] = 1'b0; s_op[i] = 2'd0; s_cnt[i] = '0;
            s_empty[i] = empty; s_afull[i] = afull; s_eob[i] = 1'b0;
        end
    endtask

    task automatic put_cmd(input int c, input logic [1:0] op, input int cnt);
        s_cv[c] = 1'b1; s_op[c] = op; s_cnt[c] = CNT_W'(cnt);
    endtask

    // Timeline model: a command accepted at t may pulse from t+1 on, each pulse pushes the
    // next allowed pulse (and the start of the starvation window) GAP_CYC+1 cycles out, and
    // a finishing pulse schedules done at that same point unless an abort lands first.
    task automatic ref_model(input int len);
        int c, d, t, n, earliest, starve, fin;
        bit eobm;
        logic [1:0] nst;
        for (int i = 0; i <= len; i++) begin
            e_rd[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_rej[i] = 0;
            e_st[i] = m_status; e_iss[i] = m_issued;
        end
        t = 0;
        while (t < len) begin
            e_st[t] = m_status; e_iss[t] = m_issued;
            if (s_cv[t] && s_op[t] <= 2'd1) begin
                m_status = ST_OK; m_issued = '0;
                eobm = (s_op[t] == 2'd1);
                n = 0; earliest = t + 1; starve = t + 1; fin = -1; d = -1; nst = ST_OK;
                if (!eobm && s_cnt[t] == '0) d = t + 1;
                c = t + 1;
                while (d < 0 && c < len) begin
                    if (c == fin) begin
                        d = c;
                    end else begin
                        e_busy[c] = 1; e_st[c] = m_status; e_iss[c] = m_issued;
                        if (s_cv[c] && s_op[c] <= 2'd1) e_rej[c+1] = 1;
                        if (s_cv[c] && s_op[c] == 2'd2) begin
                            d = c + 1; nst = ST_ABORT;
                        end else if (fin < 0 && c >= earliest) begin
                            if (!s_empty[c] && !s_afull[c]) begin
                                e_rd[c] = 1; n++;
                                if (m_issued != CNT_MAX) m_issued = m_issued + 1'b1;
                                earliest = c + GAP_CYC + 1;
                                starve = earliest;
                                if ((!eobm && n == int'(s_cnt[t])) || (eobm && s_eob[c])) fin = earliest;
                            end else if (TMO_CYC != 0 && c - starve >= TMO_CYC - 1) begin
                                d = c + 1; nst = ST_TMO;
                            end
                        end
                        c++;
                    end
                end
                if (d >= 0 && d < len) begin
                    e_busy[d] = 1; e_done[d] = 1; m_status = nst;
                    e_st[d] = nst; e_iss[d] = m_issued;
                    if (s_cv[d] && s_op[d] <= 2'd1) e_rej[d+1] = 1;
                end
                t = (d < 0) ? len : d + 1;
            end else begin
                t++;
            end
        end
    endtask

    task automatic run_seg(input string name, input int len);
        ref_model(len);
        q_rd.delete(); done_c = -1; n_done = 0; n_rej = 0; done_st = 2'd3;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            bus.cmd_valid     = s_cv[c];
            bus.cmd_op        = s_op[c];
            bus.cmd_count     = s_cnt[c];
            bus.fifo_empty    = s_empty[c];
            bus.ob_afull      = s_afull[c];
            bus.fifo_head_eob = s_eob[c];
            #1;
            if (bus.single_step_rd) q_rd.push_back(c);
            if (bus.done) begin done_c = c; done_st = bus.done_status; n_done++; end
            if (bus.cmd_rejected) n_rej++;
            chk($sformatf("%s_out@%0d", name, c),
                pack(bus.single_step_rd, bus.busy, bus.done, bus.cmd_rejected, bus.done_status, bus.issued_cnt),
                pack(e_rd[c], e_busy[c], e_done[c], e_rej[c], e_st[c], e_iss[c]));
        end
        last_iss = bus.issued_cnt;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_count = '0;
        bus.fifo_empty = 1'b1; bus.fifo_head_eob = 1'b0; bus.ob_afull = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state",
            pack(bus.single_step_rd, bus.busy, bus.done, bus.cmd_rejected, bus.done_status, bus.issued_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // STEP_N 3: pulses at +1,+4,+7, done at +10
        seg_clear(20, 0, 0); put_cmd(0, 2'd0, 3); run_seg("t1", 20);
        chk("t1_npulse", q_rd.size(), 3);
        chk("t1_p0", qget(0), 1); chk("t1_p1", qget(1), 4); chk("t1_p2", qget(2), 7);
        chk("t1_done_at", done_c, 10); chk("t1_status", done_st, ST_OK); chk("t1_issued", last_iss, 3);

        // STEP_N 0: immediate done
        seg_clear(8, 0, 0); put_cmd(0, 2'd0, 0); run_seg("t2", 8);
        chk("t2_npulse", q_rd.size(), 0); chk("t2_done_at", done_c, 1); chk("t2_status", done_st, ST_OK);

        // STEP_EOB with EOB on the third head entry
        seg_clear(16, 0, 0); put_cmd(0, 2'd1, 0);
        for (int c = 5; c <= 7; c++) s_eob[c] = 1'b1;
        run_seg("t3", 16);
        chk("t3_npulse", q_rd.size(), 3); chk("t3_done_at", done_c, 10); chk("t3_issued", last_iss, 3);

        // STEP_N 5 with afull for 10 cycles after the 2nd pulse
        seg_clear(32, 0, 0); put_cmd(0, 2'd0, 5);
        for (int c = 5; c <= 14; c++) s_afull[c] = 1'b1;
        run_seg("t4", 32);
        chk("t4_npulse", q_rd.size(), 5); chk("t4_p2", qget(2), 15); chk("t4_p4", qget(4), 21);
        chk("t4_done_at", done_c, 24); chk("t4_status", done_st, ST_OK);

        // Starvation timeout
        seg_clear(24, 1, 0); put_cmd(0, 2'd0, 2); run_seg("t5", 24);
        chk("t5_npulse", q_rd.size(), 0); chk("t5_done_at", done_c, 17);
        chk("t5_status", done_st, ST_TMO); chk("t5_issued", last_iss, 0);

        // Abort after 2nd pulse, STEP while busy, ABORT/op3 in idle ignored
        seg_clear(14, 0, 0); put_cmd(0, 2'd0, 8); put_cmd(3, 2'd1, 4); put_cmd(5, 2'd2, 0);
        put_cmd(9, 2'd2, 0); put_cmd(11, 2'd3, 5);
        run_seg("t6", 14);
        chk("t6_rej", n_rej, 1); chk("t6_done_at", done_c, 6); chk("t6_ndone", n_done, 1);
        chk("t6_status", done_st, ST_ABORT); chk("t6_issued", last_iss, 2); chk("t6_npulse", q_rd.size(), 2);

        // issued_cnt saturation during a long STEP_EOB
        seg_clear(80, 0, 0); put_cmd(0, 2'd1, 0);
        for (int c = 60; c < 80; c++) s_eob[c] = 1'b1;
        run_seg("t7", 80);
        chk("t7_npulse", q_rd.size(), 21); chk("t7_done_at", done_c, 64); chk("t7_issued", last_iss, CNT_MAX);

        // Randomized segments
        for (int s = 0; s < 4; s++) begin
            bit e, a;
            e = 1'($urandom_range(0, 1)); a = 1'b0;
            seg_clear(650, 0, 0);
            for (int c = 0; c < 650; c++) begin
                if ($urandom_range(0, 7) == 0) e = ~e;
                if ($urandom_range(0, 11) == 0) a = ~a;
                s_empty[c] = (c < 400) ? e : 1'b0;
                s_afull[c] = (c < 400) ? a : 1'b0;
                s_eob[c]   = ($urandom_range(0, 3) == 0);
                if (c < 400 && $urandom_range(0, 19) == 0)
                    put_cmd(c, 2'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
            end
            run_seg($sformatf("rnd%0d", s), 650);
        end

        // Asynchronous reset in the middle of a command cuts the pulse at once
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_count = CNT_W'(8);
        bus.fifo_empty = 1'b0; bus.ob_afull = 1'b0; bus.fifo_head_eob = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        chk("mid_rd_before_rst", bus.single_step_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state",
            pack(bus.single_step_rd, bus.busy, bus.done, bus.cmd_rejected, bus.done_status, bus.issued_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_status = ST_OK; m_issued = '0;

        seg_clear(20, 0, 0); put_cmd(0, 2'd0, 2); run_seg("post", 20);
        chk("post_done_at", done_c, 7); chk("post_issued", last_iss, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
